// File: rtl/adc_capture_port.sv
// ADC capture peripheral on the 6502 test-unit bus: a programmable-rate sampler
// that fills a small FIFO, read back through CTRL/STATUS/DATA/DIV byte registers.
module adc_capture_port #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  DIV_INIT   = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic [7:0] adc_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAP = 2'd1, ST_DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          arm_q, arm_d, cont_q, cont_d, irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d, done_q, done_d, irq_q, irq_d;
  logic [7:0]    div_q, div_d, cnt_q, cnt_d, dout_q, dout_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [7:0]    mem [DEPTH];

  logic ctrl_wr, stat_wr, div_wr, data_rd, flush;
  logic empty, full, strobe, pop, push, drop, make_done;

  assign ctrl_wr = cs & we & (addr == 2'd0);
  assign stat_wr = cs & we & (addr == 2'd1);
  assign div_wr  = cs & we & (addr == 2'd3);
  assign data_rd = cs & ~we & (addr == 2'd2);
  assign flush   = ctrl_wr & din[7];

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

  // >= rather than == so a DIV lowered mid-capture cannot strand the divider
  assign strobe    = (state_q == ST_CAP) && (cnt_q >= div_q);
  assign pop       = data_rd & ~empty;
  assign push      = strobe & ~flush & (~full | pop);
  assign drop      = strobe & ~flush & full & ~pop;
  assign make_done = push & ~pop & (count == PW'(DEPTH - 1)) & ~cont_q;

  always_comb begin
    arm_d    = arm_q;
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      arm_d    = din[0];
      cont_d   = din[1];
      irq_en_d = din[2];
    end
    div_d = div_wr ? din : div_q;

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    ovf_d  = ovf_q | drop;
    done_d = done_q | make_done;
    // CPU clears take priority over a same-cycle set
    if (stat_wr && din[2]) ovf_d  = 1'b0;
    if (stat_wr && din[3]) done_d = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end

    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: if (arm_d) state_d = ST_CAP;
      ST_CAP: begin
        if (!arm_d)         state_d = ST_IDLE;
        else if (make_done) state_d = ST_DONE;
        else                cnt_d   = strobe ? 8'd0 : cnt_q + 8'd1;
      end
      ST_DONE: begin
        if (!arm_d)     state_d = ST_IDLE;
        else if (flush) state_d = ST_CAP;
      end
      default: state_d = ST_IDLE;
    endcase

    dout_d = dout_q;
    if (cs && !we) begin
      case (addr)
        2'd0: dout_d = {5'b0, irq_en_q, cont_q, arm_q};
        2'd1: dout_d = {2'b0, state_q, done_q, ovf_q, full, empty};
        2'd2: dout_d = empty ? 8'h00 : mem[rptr_q[PW-2:0]];
        default: dout_d = div_q;
      endcase
    end

    irq_d = irq_en_q & (done_q | ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      arm_q    <= 1'b0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= DIV_INIT;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      cont_q   <= cont_d;
      irq_en_q <= irq_en_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  // sample storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[PW-2:0]] <= adc_data;
  end

  assign dout = dout_q;
  assign irq  = irq_q;
endmodule

// File: tb/tb_adc_capture_port.sv
// Randomized bench for adc_capture_port: a queue-based reference model predicts
// every register read; a monitor compares dout the cycle after each read.
module tb_adc_capture_port;
  logic       clk = 1'b0;
  logic       reset_n, cs, we;
  logic [1:0] addr;
  logic [7:0] din, adc_data, dout;
  logic       irq;

  always #5 clk = ~clk;

  adc_capture_port dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .irq(irq), .adc_data(adc_data)
  );

  int checks = 0, failures = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  // reference model state
  int         m_state, t, m_next;
  bit         m_arm, m_cont, m_irqen, m_ovf, m_done, m_irq;
  logic [7:0] m_div;
  logic [7:0] m_fifo[$];

  task automatic model_reset();
    m_state = 0; m_arm = 0; m_cont = 0; m_irqen = 0;
    m_ovf = 0; m_done = 0; m_irq = 0; m_div = 8'h00;
    m_fifo.delete();
    m_next = 0;
  endtask

  // Advance the model across one clock edge given the bus inputs of that cycle.
  task automatic model_step(input bit c, input bit w, input logic [1:0] a,
                            input logic [7:0] d, input logic [7:0] adc);
    bit rd, wr, flush, strobe, popped, pushed, mk_done, narm, ncont, nirq, old_irq;
    logic [7:0] r;
    logic [1:0] st;
    string nm;
    rd = c && !w;
    wr = c && w;
    old_irq = m_irqen && (m_done || m_ovf);
    if (rd) begin
      st = m_state[1:0];
      case (a)
        2'd0: begin r = {5'b0, m_irqen, m_cont, m_arm}; nm = "ctrl"; end
        2'd1: begin r = {2'b0, st, m_done, m_ovf, m_fifo.size() == 16, m_fifo.size() == 0}; nm = "status"; end
        2'd2: begin r = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00; nm = "data"; end
        default: begin r = m_div; nm = "div"; end
      endcase
      exp_q.push_back(r);
      name_q.push_back(nm);
    end
    popped = rd && (a == 2'd2) && (m_fifo.size() > 0);
    if (popped) void'(m_fifo.pop_front());
    narm = m_arm; ncont = m_cont; nirq = m_irqen;
    flush = 0;
    if (wr && a == 2'd0) begin
      narm = d[0]; ncont = d[1]; nirq = d[2]; flush = d[7];
    end
    strobe = (m_state == 1) && (t == m_next);
    if (strobe) m_next = t + int'(m_div) + 1;
    pushed = 0;
    if (strobe && !flush) begin
      if (m_fifo.size() < 16) begin m_fifo.push_back(adc); pushed = 1; end
      else m_ovf = 1;
    end
    mk_done = pushed && !popped && m_fifo.size() == 16 && !m_cont;
    if (mk_done) m_done = 1;
    if (wr && a == 2'd1) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_done = 0;
    end
    if (flush) begin m_fifo.delete(); m_ovf = 0; m_done = 0; end
    if (wr && a == 2'd3) m_div = d;
    case (m_state)
      0: if (narm) begin m_state = 1; m_next = t + int'(m_div) + 1; end
      1: if (!narm) m_state = 0; else if (mk_done) m_state = 2;
      default: if (!narm) m_state = 0;
               else if (flush) begin m_state = 1; m_next = t + int'(m_div) + 1; end
    endcase
    m_arm = narm; m_cont = ncont; m_irqen = nirq;
    m_irq = old_irq;
    t++;
  endtask

  task automatic tick_adc(input bit c, input bit w, input logic [1:0] a,
                          input logic [7:0] d, input logic [7:0] adc);
    cs = c; we = w; addr = a; din = d; adc_data = adc;
    model_step(c, w, a, d, adc);
    @(posedge clk); #1;
    checks++;
    if (irq !== m_irq) begin
      failures++;
      $display("FAIL irq t=%0d got=%b exp=%b", t, irq, m_irq);
    end
  endtask

  task automatic tick(input bit c, input bit w, input logic [1:0] a, input logic [7:0] d);
    tick_adc(c, w, a, d, 8'($urandom));
  endtask

  task automatic rd(input logic [1:0] a);                  tick(1, 0, a, 8'h00); endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d); tick(1, 1, a, d);  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 8'h00);
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // monitor: dout is valid the cycle after a read edge
  bit pend;
  always begin
    @(posedge clk);
    pend = cs && !we && reset_n;
    @(negedge clk);
    if (pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read got=%h exp=none", dout);
      end else begin
        logic [7:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL rd_%s got=%h exp=%h", n, dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    t = 0;
    model_reset();
    reset_n = 1'b0; cs = 0; we = 0; addr = 0; din = 0; adc_data = 0;
    #3;
    check("reset_dout", dout, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    #9 reset_n = 1'b1;

    rd(2'd1);                 // 01
    rd(2'd2);                 // empty read -> 00
    rd(2'd1);                 // still empty
    rd(2'd3);                 // DIV reset value
    idle(1);

    // one-shot, DIV=3, ramp samples 0x10, 0x11, ...
    wr(2'd3, 8'h03);
    wr(2'd0, 8'h05);
    for (int j = 1; j <= 64; j++) begin
      if (j == 4 || j == 5) tick_adc(1, 0, 2'd1, 8'h00, 8'h0F + 8'(j / 4));
      else                  tick_adc(0, 0, 2'd0, 8'h00, 8'h0F + 8'(j / 4));
    end
    rd(2'd1);                 // 2A
    idle(1);
    check("irq_done", {7'b0, irq}, 8'h01);
    for (int i = 0; i < 16; i++) rd(2'd2);
    rd(2'd2);                 // empty -> 00
    rd(2'd1);                 // 29
    rd(2'd0);

    // flush from DONE restarts capture
    wr(2'd0, 8'h81);
    rd(2'd1);
    idle(2);
    rd(2'd1);
    rd(2'd1);
    rd(2'd2);
    wr(2'd0, 8'h00);
    idle(2);

    // continuous overflow, DIV=0
    wr(2'd0, 8'h80);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h07);
    idle(20);
    rd(2'd1);                 // 16
    wr(2'd1, 8'h04);          // clear overflow
    rd(2'd2);                 // pop on a strobe edge: oldest value, no overflow
    rd(2'd1);                 // 12
    rd(2'd1);                 // overflow again
    idle(1);

    // asynchronous reset mid-capture
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 8'h00);
    check("async_rst_irq", {7'b0, irq}, 8'h00);
    cs = 0;
    model_reset();
    #2 reset_n = 1'b1;
    idle(3);
    rd(2'd1);                 // 01, capture did not resume
    idle(1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      int op;
      op = $urandom_range(0, 11);
      case (op)
        0:       if (m_state != 1) wr(2'd3, 8'($urandom_range(0, 3))); else idle(1);
        1:       wr(2'd0, 8'($urandom) & 8'h87);
        2:       wr(2'd0, 8'($urandom) & 8'h07);
        3:       wr(2'd1, 8'($urandom) & 8'h0C);
        4, 5, 6: rd(2'd2);
        7:       rd(2'd1);
        8:       rd(2'($urandom_range(0, 3)));
        9:       wr(2'd2, 8'($urandom));
        default: idle(1);
      endcase
    end
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
